stream_asyn_fifo_wframer: RTL and testbench

Write-side frame front end for the stream asynchronous FIFO. It accepts a framed valid/ready stream and converts each beat into the 3-bit write command plus data consumed by the FIFO write controller, `stream_asyn_fifo_write`. It appends per-frame head words, discards errored or oversize frames, and flags protocol faults. It sits in the write clock domain, directly upstream of the controller and RAM write port.

---
 rtl/stream_fifo_pkg.sv | 24 ++
 rtl/stream_frame_head_gen.sv | 25 ++
 rtl/stream_asyn_fifo_wframer.sv | 182 ++++++++++++++++++
 tb/tb_stream_asyn_fifo_wframer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Command codes and framer state shared by the stream FIFO write path.
// Latency: n/a (types only).  Backpressure: n/a.
package stream_fifo_pkg;

    typedef enum logic [2:0] {
        CMD_NOP            = 3'd0,
        CMD_WRITE          = 3'd1,
        CMD_EOF_WITH_WRITE = 3'd2,
        CMD_HEAD           = 3'd4,
        CMD_FINAL_HEAD     = 3'd5,
        CMD_DISCARD        = 3'd6
    } w_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_HEAD,
        ST_DROP
    } framer_state_e;

    localparam int SEQW = 16;
    localparam int CNTW = 16;

endpackage

// File: rtl/stream_frame_head_gen.sv
// Builds one head word from the head index, final frame length and sequence number.
// Latency: combinational.  Backpressure: none, pure function of inputs.
module stream_frame_head_gen
    import stream_fifo_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int LENW      = 7,
    parameter int IDXW      = 1
) (
    input  logic [IDXW-1:0]      idx,
    input  logic [LENW-1:0]      len,
    input  logic [SEQW-1:0]      seq,
    output logic [DATAWIDTH-1:0] head
);

    always_comb begin
        head = '0;
        if (idx == IDXW'(0)) begin
            head = DATAWIDTH'(len);
        end else if (idx == IDXW'(1)) begin
            head = DATAWIDTH'(seq);
        end
    end

endmodule

// File: rtl/stream_asyn_fifo_wframer.sv
// Write-side framer: turns a sop/eop stream into FIFO write commands, appends head words, drops bad frames.
// Latency: zero, w_ctrl/w_data are combinational from state and the current beat.
// Backpressure: s_ready follows !w_full; forced low during head insertion and on a stray sop in DATA.
module stream_asyn_fifo_wframer
    import stream_fifo_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 6,
    parameter int HEADSIZE  = 0,
    parameter int MAXLEN    = 40
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATAWIDTH-1:0] s_data,
    input  logic                 s_sop,
    input  logic                 s_eop,
    input  logic                 s_err,
    input  logic                 w_full,
    output logic [2:0]           w_ctrl,
    output logic [DATAWIDTH-1:0] w_data,
    output logic [CNTW-1:0]      frm_ok_cnt,
    output logic [CNTW-1:0]      frm_drop_cnt,
    output logic                 proto_err
);

    localparam int LENW = ADDRWIDTH + 1;
    localparam int IDXW = (HEADSIZE > 1) ? $clog2(HEADSIZE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'((HEADSIZE > 0) ? HEADSIZE - 1 : 0);
    localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

    framer_state_e  state_q, state_d;
    logic [LENW-1:0] len_q, len_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [SEQW-1:0] seq_q;
    logic [CNTW-1:0] ok_q, drop_q;
    logic            perr_q;

    w_cmd_e                 cmd;
    logic                   ready;
    logic                   ok_inc, drop_inc, seq_inc, perr_set, eof_beat;
    logic [DATAWIDTH-1:0]   head_word;

    stream_frame_head_gen #(
        .DATAWIDTH (DATAWIDTH),
        .LENW      (LENW),
        .IDXW      (IDXW)
    ) u_head_gen (
        .idx  (idx_q),
        .len  (len_q),
        .seq  (seq_q),
        .head (head_word)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        cmd      = CMD_NOP;
        ready    = 1'b0;
        ok_inc   = 1'b0;
        drop_inc = 1'b0;
        seq_inc  = 1'b0;
        perr_set = 1'b0;
        eof_beat = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready = !w_full;
                if (s_valid && ready) begin
                    if (s_sop) begin
                        len_d = LENW'(1);
                        cmd   = CMD_WRITE;
                        if (s_eop) eof_beat = 1'b1;
                        else       state_d  = ST_DATA;
                    end else begin
                        perr_set = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                // A sop here means the previous frame lost its eop: kill it,
                // stall this beat and restart it from IDLE next cycle.
                if (s_valid && s_sop) begin
                    cmd      = CMD_DISCARD;
                    drop_inc = 1'b1;
                    perr_set = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    ready = !w_full;
                    if (s_valid && ready) begin
                        if (len_q == MAXLEN_L) begin
                            cmd      = CMD_DISCARD;
                            drop_inc = 1'b1;
                            state_d  = s_eop ? ST_IDLE : ST_DROP;
                        end else begin
                            len_d = len_q + 1'b1;
                            cmd   = CMD_WRITE;
                            if (s_eop) eof_beat = 1'b1;
                        end
                    end
                end
            end
            ST_HEAD: begin
                if (!w_full) begin
                    if (idx_q == LAST_IDX) begin
                        cmd     = CMD_FINAL_HEAD;
                        ok_inc  = 1'b1;
                        seq_inc = 1'b1;
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cmd   = CMD_HEAD;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_DROP: begin
                ready = 1'b1;
                if (s_valid) begin
                    if (s_sop) perr_set = 1'b1;
                    if (s_eop) state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (eof_beat) begin
            if (s_err) begin
                cmd      = CMD_DISCARD;
                drop_inc = 1'b1;
                state_d  = ST_IDLE;
            end else if (HEADSIZE == 0) begin
                cmd     = CMD_EOF_WITH_WRITE;
                ok_inc  = 1'b1;
                seq_inc = 1'b1;
                state_d = ST_IDLE;
            end else begin
                cmd     = CMD_EOF_WITH_WRITE;
                idx_d   = '0;
                state_d = ST_HEAD;
            end
        end
    end

    always_comb begin
        w_data = '0;
        case (cmd)
            CMD_WRITE, CMD_EOF_WITH_WRITE: w_data = s_data;
            CMD_HEAD, CMD_FINAL_HEAD:      w_data = head_word;
            default:                       w_data = '0;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            seq_q   <= '0;
            ok_q    <= '0;
            drop_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            if (seq_inc)                    seq_q  <= seq_q + 1'b1;
            if (ok_inc && ok_q != '1)       ok_q   <= ok_q + 1'b1;
            if (drop_inc && drop_q != '1)   drop_q <= drop_q + 1'b1;
            if (perr_set)                   perr_q <= 1'b1;
        end
    end

    assign s_ready      = ready;
    assign w_ctrl       = cmd;
    assign frm_ok_cnt   = ok_q;
    assign frm_drop_cnt = drop_q;
    assign proto_err    = perr_q;

endmodule

// File: tb/tb_stream_asyn_fifo_wframer.sv
// Directed bench: one HEADSIZE=0 instance for streaming, one HEADSIZE=2 instance for heads, drops and faults.
module tb_stream_asyn_fifo_wframer;

    logic        w_clk = 1'b0;
    logic        w_rst_n;
    always #5 w_clk = ~w_clk;

    // HEADSIZE=2 instance
    logic        valid, sop, eop, err, full, ready, perr;
    logic [31:0] data, wdata;
    logic [2:0]  ctrl;
    logic [15:0] ok, drop;

    // HEADSIZE=0 instance
    logic        valid0, sop0, eop0, err0, full0, ready0, perr0;
    logic [31:0] data0, wdata0;
    logic [2:0]  ctrl0;
    logic [15:0] ok0, drop0;

    int checks = 0;
    int errors = 0;

    stream_asyn_fifo_wframer #(.DATAWIDTH(32), .ADDRWIDTH(6), .HEADSIZE(2), .MAXLEN(40)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .s_valid(valid), .s_ready(ready), .s_data(data),
        .s_sop(sop), .s_eop(eop), .s_err(err), .w_full(full), .w_ctrl(ctrl), .w_data(wdata),
        .frm_ok_cnt(ok), .frm_drop_cnt(drop), .proto_err(perr)
    );

    stream_asyn_fifo_wframer #(.DATAWIDTH(32), .ADDRWIDTH(6), .HEADSIZE(0), .MAXLEN(40)) dut0 (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .s_valid(valid0), .s_ready(ready0), .s_data(data0),
        .s_sop(sop0), .s_eop(eop0), .s_err(err0), .w_full(full0), .w_ctrl(ctrl0), .w_data(wdata0),
        .frm_ok_cnt(ok0), .frm_drop_cnt(drop0), .proto_err(perr0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] d, input logic s, input logic e,
                       input logic r, input logic f);
        valid = v; data = d; sop = s; eop = e; err = r; full = f;
        #1;
    endtask

    task automatic drv0(input logic v, input logic [31:0] d, input logic s, input logic e);
        valid0 = v; data0 = d; sop0 = s; eop0 = e; err0 = 1'b0; full0 = 1'b0;
        #1;
    endtask

    initial begin
        w_rst_n = 1'b0;
        valid = 0; data = 0; sop = 0; eop = 0; err = 0; full = 0;
        valid0 = 0; data0 = 0; sop0 = 0; eop0 = 0; err0 = 0; full0 = 0;
        #2;
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_ok", 32'(ok), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        tick();
        w_rst_n = 1'b1;
        tick();

        // 1: HEADSIZE=0 streaming, then a single-beat frame back to back
        drv0(1, 32'hA, 1, 0);
        chk("t1_ctrl_a", 32'(ctrl0), 32'd1);
        chk("t1_data_a", wdata0, 32'hA);
        tick();
        drv0(1, 32'hB, 0, 0);
        chk("t1_ctrl_b", 32'(ctrl0), 32'd1);
        chk("t1_data_b", wdata0, 32'hB);
        tick();
        drv0(1, 32'hC, 0, 1);
        chk("t1_ctrl_c", 32'(ctrl0), 32'd2);
        chk("t1_data_c", wdata0, 32'hC);
        tick();
        drv0(1, 32'hD, 1, 1);
        chk("t1_ok1", 32'(ok0), 32'd1);
        chk("t1_ready_d", 32'(ready0), 32'd1);
        chk("t1_ctrl_d", 32'(ctrl0), 32'd2);
        tick();
        drv0(0, 32'h0, 0, 0);
        chk("t1_ok2", 32'(ok0), 32'd2);
        chk("t1_ctrl_idle", 32'(ctrl0), 32'd0);

        // 2: HEADSIZE=2, 4-beat frame, next frame held off during heads
        drv(1, 32'd10, 1, 0, 0, 0);
        chk("t2_ctrl_b1", 32'(ctrl), 32'd1);
        chk("t2_data_b1", wdata, 32'd10);
        tick();
        drv(1, 32'd11, 0, 0, 0, 0);
        chk("t2_ctrl_b2", 32'(ctrl), 32'd1);
        tick();
        drv(1, 32'd12, 0, 0, 0, 0);
        chk("t2_ctrl_b3", 32'(ctrl), 32'd1);
        tick();
        drv(1, 32'd13, 0, 1, 0, 0);
        chk("t2_ctrl_eof", 32'(ctrl), 32'd2);
        chk("t2_data_eof", wdata, 32'd13);
        tick();
        drv(1, 32'd20, 1, 0, 0, 0);
        chk("t2_ready_h0", 32'(ready), 32'd0);
        chk("t2_ctrl_h0", 32'(ctrl), 32'd4);
        chk("t2_data_h0", wdata, 32'd4);
        tick();
        chk("t2_ready_h1", 32'(ready), 32'd0);
        chk("t2_ctrl_h1", 32'(ctrl), 32'd5);
        chk("t2_data_h1", wdata, 32'd0);
        tick();
        chk("t2_ok1", 32'(ok), 32'd1);
        chk("t2_ready_f2", 32'(ready), 32'd1);
        chk("t2_ctrl_f2", 32'(ctrl), 32'd1);
        chk("t2_data_f2", wdata, 32'd20);
        tick();
        drv(1, 32'd21, 0, 1, 0, 0);
        chk("t2_ctrl_f2eof", 32'(ctrl), 32'd2);
        tick();
        drv(0, 32'd0, 0, 0, 0, 0);
        chk("t2_data_f2h0", wdata, 32'd2);
        tick();
        chk("t2_ctrl_f2h1", 32'(ctrl), 32'd5);
        chk("t2_data_f2h1", wdata, 32'd1);
        tick();
        chk("t2_ok2", 32'(ok), 32'd2);

        // 3: errored frame is discarded and does not advance seq
        for (int i = 0; i < 5; i++) begin
            drv(1, 32'(30 + i), 1'(i == 0), 1'(i == 4), 1'(i == 4), 0);
            chk("t3_ctrl", 32'(ctrl), (i < 4) ? 32'd1 : 32'd6);
            tick();
        end
        drv(1, 32'd40, 1, 1, 0, 0);
        chk("t3_drop1", 32'(drop), 32'd1);
        chk("t3_ctrl_single", 32'(ctrl), 32'd2);
        tick();
        drv(0, 32'd0, 0, 0, 0, 0);
        chk("t3_data_h0", wdata, 32'd1);
        tick();
        chk("t3_data_h1_seq", wdata, 32'd2);
        tick();
        chk("t3_ok3", 32'(ok), 32'd3);

        // 4: oversize frame, 45 beats against MAXLEN=40
        for (int i = 1; i <= 45; i++) begin
            drv(1, 32'(100 + i), 1'(i == 1), 1'(i == 45), 0, 0);
            chk("t4_ctrl", 32'(ctrl), (i <= 40) ? 32'd1 : ((i == 41) ? 32'd6 : 32'd0));
            chk("t4_ready", 32'(ready), 32'd1);
            tick();
        end
        drv(0, 32'd0, 0, 0, 0, 0);
        chk("t4_drop2", 32'(drop), 32'd2);
        chk("t4_ok", 32'(ok), 32'd3);
        chk("t4_perr", 32'(perr), 32'd0);

        // 5: w_full windows in DATA and in HEAD
        drv(1, 32'd50, 1, 0, 0, 0);
        chk("t5_ctrl_b1", 32'(ctrl), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1, 32'd51, 0, 0, 0, 1);
            chk("t5_full_ready", 32'(ready), 32'd0);
            chk("t5_full_ctrl", 32'(ctrl), 32'd0);
            tick();
        end
        drv(1, 32'd51, 0, 0, 0, 0);
        chk("t5_ctrl_b2", 32'(ctrl), 32'd1);
        chk("t5_data_b2", wdata, 32'd51);
        tick();
        drv(1, 32'd52, 0, 0, 0, 0);
        chk("t5_data_b3", wdata, 32'd52);
        tick();
        drv(1, 32'd53, 0, 1, 0, 0);
        chk("t5_ctrl_eof", 32'(ctrl), 32'd2);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(0, 32'd0, 0, 0, 0, 1);
            chk("t5_hfull_ctrl", 32'(ctrl), 32'd0);
            chk("t5_hfull_ready", 32'(ready), 32'd0);
            tick();
        end
        drv(0, 32'd0, 0, 0, 0, 0);
        chk("t5_ctrl_h0", 32'(ctrl), 32'd4);
        chk("t5_data_h0", wdata, 32'd4);
        tick();
        chk("t5_ctrl_h1", 32'(ctrl), 32'd5);
        chk("t5_data_h1", wdata, 32'd3);
        tick();
        chk("t5_ok4", 32'(ok), 32'd4);

        // 6: sop inside DATA, then reset pulsed during HEAD
        drv(1, 32'd60, 1, 0, 0, 0);
        chk("t6_ctrl_b1", 32'(ctrl), 32'd1);
        tick();
        drv(1, 32'd61, 1, 0, 0, 0);
        chk("t6_ready_stray", 32'(ready), 32'd0);
        chk("t6_ctrl_discard", 32'(ctrl), 32'd6);
        chk("t6_data_discard", wdata, 32'd0);
        tick();
        chk("t6_perr", 32'(perr), 32'd1);
        chk("t6_drop3", 32'(drop), 32'd3);
        chk("t6_ready_restart", 32'(ready), 32'd1);
        chk("t6_ctrl_restart", 32'(ctrl), 32'd1);
        chk("t6_data_restart", wdata, 32'd61);
        tick();
        drv(1, 32'd62, 0, 1, 0, 0);
        chk("t6_ctrl_eof", 32'(ctrl), 32'd2);
        tick();
        drv(0, 32'd0, 0, 0, 0, 0);
        chk("t6_ctrl_head", 32'(ctrl), 32'd4);
        chk("t6_data_head", wdata, 32'd2);
        w_rst_n = 1'b0;
        #1;
        chk("t6_rst_ctrl", 32'(ctrl), 32'd0);
        chk("t6_rst_ok", 32'(ok), 32'd0);
        chk("t6_rst_drop", 32'(drop), 32'd0);
        chk("t6_rst_perr", 32'(perr), 32'd0);
        chk("t6_rst_ready", 32'(ready), 32'd1);
        tick();
        w_rst_n = 1'b1;
        drv(1, 32'd70, 1, 1, 0, 0);
        chk("t6_post_ctrl", 32'(ctrl), 32'd2);
        chk("t6_post_data", wdata, 32'd70);
        tick();
        drv(0, 32'd0, 0, 0, 0, 0);
        chk("t6_post_h0", wdata, 32'd1);
        tick();
        chk("t6_post_h1_ctrl", 32'(ctrl), 32'd5);
        chk("t6_post_h1_seq", wdata, 32'd0);
        tick();
        chk("t6_post_ok", 32'(ok), 32'd1);

        // beat without sop in IDLE is swallowed and flagged
        drv(1, 32'd80, 0, 0, 0, 0);
        chk("t7_ctrl_nosop", 32'(ctrl), 32'd0);
        chk("t7_ready_nosop", 32'(ready), 32'd1);
        tick();
        drv(0, 32'd0, 0, 0, 0, 0);
        chk("t7_perr", 32'(perr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
